// File: rtl/ft60x_mode245_tx.sv
// ft60x_mode245_tx
// Transmit engine for FT600/FT601 245 synchronous FIFO mode. Producer words
// are buffered in a small circular FIFO and burst to the chip while ft_txe
// permits. A word is committed only on an edge where ft_wr=0 and ft_txe=0.
// If ft_txe rises mid-burst, the word on the bus stays at the FIFO head and
// is re-driven on the next burst.
//
// Ports:
//   clk, rst            FT CLKOUT; asynchronous active-low reset
//   in_data/in_be       producer word and byte enables
//   in_valid/in_ready   producer handshake (in_ready = FIFO not full)
//   fifo_level          stored words, including the word on the bus
//   tx_words            committed word count (wraps)
//   ft_data/ft_be       bus data/byte enables, driven when ft_data_oe=1
//   ft_txe              chip can accept data (active-low)
//   ft_wr               write strobe (active-low)
//   ft_oe, ft_rd        tied high (no receive path)
//
// state | meaning
// IDLE  | bus released, ft_wr=1; waiting for ft_txe=0 and data
// WRITE | bus driven, ft_wr=0; a word commits on each edge with ft_txe=0
module ft60x_mode245_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int FIFO_AW    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [BE_WIDTH-1:0]   in_be,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [FIFO_AW:0]      fifo_level,
  output logic [31:0]           tx_words,
  output logic [DATA_WIDTH-1:0] ft_data,
  output logic [BE_WIDTH-1:0]   ft_be,
  output logic                  ft_data_oe,
  input  logic                  ft_txe,
  output logic                  ft_wr,
  output logic                  ft_oe,
  output logic                  ft_rd
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int EW    = DATA_WIDTH + BE_WIDTH;
  localparam logic [FIFO_AW:0] FULL_LEVEL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] ONE_LEVEL  = (FIFO_AW + 1)'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t state, state_next;

  logic [EW-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   level;

  logic          push;
  logic          pop;
  logic          load;
  logic          load_next;
  logic [EW-1:0] head_word;
  logic [EW-1:0] next_word;
  logic [EW-1:0] load_word;

  assign ft_oe      = 1'b1;
  assign ft_rd      = 1'b1;
  assign in_ready   = (level != FULL_LEVEL);
  assign fifo_level = level;

  assign push = in_valid & in_ready;
  assign pop  = (state == WRITE) & ~ft_txe;

  assign head_word = mem[rd_ptr];
  // When only one word remains, its successor is the word being pushed on
  // this same edge; it is not in the array yet, so take it from the input.
  assign next_word = (level == ONE_LEVEL) ? {in_be, in_data}
                                          : mem[rd_ptr + FIFO_AW'(1)];
  assign load_word = load_next ? next_word : head_word;

  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_next  = 1'b0;
    case (state)
      IDLE: begin
        if (!ft_txe && (level != '0)) begin
          state_next = WRITE;
          load       = 1'b1;
        end
      end
      WRITE: begin
        if (!ft_txe) begin
          // remaining after pop = level - 1 + push
          if ((level > ONE_LEVEL) || push) begin
            load      = 1'b1;
            load_next = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          // no commit: head is kept and re-loaded when the next burst starts
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ft_wr      <= 1'b1;
      ft_data_oe <= 1'b0;
      ft_data    <= '0;
      ft_be      <= '0;
    end else begin
      state      <= state_next;
      ft_wr      <= (state_next != WRITE);
      ft_data_oe <= (state_next == WRITE);
      if (load) begin
        {ft_be, ft_data} <= load_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_be, in_data};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      tx_words <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + FIFO_AW'(1);
        tx_words <= tx_words + 32'd1;
      end
      case ({push, pop})
        2'b10:   level <= level + ONE_LEVEL;
        2'b01:   level <= level - ONE_LEVEL;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: doc/ft60x_mode245_tx.md
# ft60x_mode245_tx

Parametrised transmit engine for the FT600/FT601 in 245 synchronous FIFO mode. It sits between the user-side producer and the FTDI pins, buffering words in an internal FIFO and bursting them to the chip whenever `ft_txe` permits. It generalises the 16-bit TX path to a selectable bus width and FIFO depth. It also guarantees that no word is lost or duplicated when `ft_txe` deasserts mid-burst. The whole block runs in the FT clock domain.

## Interface

Parameters:
- `DATA_WIDTH`, 16: FT bus width. Legal values are 16 (FT600) and 32 (FT601).
- `BE_WIDTH`, `DATA_WIDTH/8`: derived byte-enable width. Do not override.
- `FIFO_AW`, 4: FIFO address width. Depth is `1<<FIFO_AW` words.

Ports:
- `clk`  in  1  FT CLKOUT, 100 MHz. This is the only clock. All logic is rising-edge.
- `rst`  in  1  Asynchronous, active-low reset.
- `in_data`  in  DATA_WIDTH  Producer word.
- `in_be`  in  BE_WIDTH  Producer byte enables, stored with the word.
- `in_valid`  in  1  Producer offers a word.
- `in_ready`  out  1  FIFO not full. A push occurs when `in_valid & in_ready`.
- `fifo_level`  out  FIFO_AW+1  Number of stored words, including the word currently on the bus.
- `tx_words`  out  32  Count of committed words. Wraps modulo 2^32.
- `ft_data`  out  DATA_WIDTH  Bus data. The top level tristates it.
- `ft_be`  out  BE_WIDTH  Bus byte enables.
- `ft_data_oe`  out  1  Drive enable for `ft_data`/`ft_be`.
- `ft_txe`  in  1  Active-low. Chip can accept data.
- `ft_wr`  out  1  Active-low write strobe.
- `ft_oe`  out  1  Tied 1. There is no RX path.
- `ft_rd`  out  1  Tied 1.

## Operation

- **FIFO**
  - Circular buffer with asynchronous read and registered pointers, plus a level counter.
  - Push writes `{in_be, in_data}` at `wr_ptr`.
  - Pop advances `rd_ptr`.
  - Simultaneous push and pop leaves the level unchanged.
  - Pointers wrap at depth.
  - A push while full cannot occur, because `in_ready` is 0.
- **Commit rule**: a word is transferred on a rising edge where both `ft_wr`=0 and `ft_txe`=0. A commit pops the FIFO and increments `tx_words`. No other event pops.
- **State machine**: two states, IDLE and WRITE.
  - IDLE:
    - Outputs are `ft_wr`=1 and `ft_data_oe`=0.
    - Go to WRITE when `ft_txe`=0 and `fifo_level`>0.
    - On entry, load `ft_data`/`ft_be` with the head word.
  - WRITE, committing edge (`ft_txe`=0):
    - Pop the head.
    - If the remaining level (after this pop, plus any simultaneous push) is >0, stay in WRITE and load the next head into `ft_data`/`ft_be`.
    - Otherwise go to IDLE.
  - WRITE, non-committing edge (`ft_txe`=1): no commit. Go to IDLE. The head word is retained and is re-sent on the next burst.
- **Output mapping**: `ft_wr` = not WRITE, and `ft_data_oe` = WRITE. Both are registered.
- **Width**: `in_data`, FIFO entries and `ft_data` all have the same width. There is no packing.

## Timing

- **Reset values**:
  - `ft_wr`=1, `ft_data_oe`=0, `ft_data`=0, `ft_be`=0.
  - `fifo_level`=0, `in_ready`=1, `tx_words`=0.
  - State IDLE, pointers 0.
  - `ft_oe`=`ft_rd`=1 at all times.
- **Latency**
  - A push at edge N into an empty FIFO with `ft_txe`=0 gives `ft_wr`=0 after edge N+1, and the word commits at edge N+2.
- **Throughput**
  - One word per cycle while `ft_txe`=0 and the FIFO is non-empty.
  - A push made on the edge that would otherwise empty the FIFO keeps the burst going with no bubble.
- **`ft_txe` rising mid-burst**
  - The word on the bus at that edge is not popped.
  - `ft_wr` is 1 after that edge.
  - When `ft_txe` next falls, the same word is re-driven first.
- **`ft_txe` falling while IDLE**: one cycle of latency to `ft_wr`=0.
- **Full FIFO**
  - `in_ready`=0 while `fifo_level` = depth.
  - It returns to 1 in the cycle after the first commit.
- **Reset mid-burst**
  - Outputs take their reset values asynchronously.
  - FIFO contents are discarded and `tx_words` clears.

## Test plan

- **Reset**: hold `rst`=0 for 5 cycles with `in_valid`=1. Required response: `ft_wr`=1, `ft_data_oe`=0, `fifo_level`=0, `tx_words`=0, and no push.
- **Basic burst**: `ft_txe`=1, push 0x1111, 0x2222, 0x3333, 0x4444, then set `ft_txe`=0. Required response:
  - `fifo_level`=4.
  - Four consecutive commits in order with `ft_be`=2'b11.
  - `tx_words`=4, then `ft_wr`=1 and `ft_data_oe`=0.
- **Mid-burst stall**: same 4 words, with `ft_txe` high for one cycle during the commit of 0x2222. Required response:
  - 0x2222 is not popped.
  - Bus sequence is 0x1111, 0x2222 (re-sent), 0x3333, 0x4444.
  - `tx_words`=4 with no duplicates.
- **Full FIFO**: `ft_txe`=1, push 17 words. Required response:
  - `in_ready`=0 after 16 pushes and `fifo_level`=16.
  - Word 17 is held off.
  - After `ft_txe`=0, `in_ready`=1 in the cycle after the first commit.
  - All 17 words arrive in order.
- **Streaming boundary**: `ft_txe`=0, level 1, with a push on the committing edge. Required response: `ft_wr` stays 0 and the next word appears with no idle cycle.
- **Reset mid-burst, 32-bit instance** (`DATA_WIDTH`=32): reset asserted during a 4-word burst. Required response:
  - `ft_wr`=1 immediately.
  - After release, a new push of 0xDEADBEEF with `in_be`=4'b0111 appears on `ft_data`/`ft_be` unchanged.
